seq_scan_ctrl: RTL
==================

Name: seq_scan_ctrl

Overview:
- Controller that feeds a programmable 4-bit overlapping pattern detector.
- Accepts parallel words over a valid/ready handshake and serialises each word MSB-first, one bit per clock.
- Detects the pattern as a Moore machine: the match pulse is registered one cycle after the completing bit.
- Returns a per-word match count over a second valid/ready handshake; sits between a word-oriented producer and the serial detection datapath.

Parameters:
WORD_W, 8, bits per input word (>=4)
CNT_W, 4, width of per-word match count (must hold WORD_W)
TOT_W, 16, width of saturating total-match counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_we  input  1  pattern write strobe (honoured only in IDLE)
cfg_pattern  input  4  new pattern, oldest bit in [3]
in_valid  input  1  word available
in_ready  output  1  controller can accept a word
in_data  input  WORD_W  word to scan, MSB sent first
bit_out  output  1  bit currently being scanned (debug/tap)
bit_valid  output  1  bit_out consumed this cycle
z  output  1  registered match pulse
out_valid  output  1  match_count valid
out_ready  input  1  consumer accepts result
match_count  output  CNT_W  matches completed within this word
total_matches  output  TOT_W  saturating count of all matches since reset
busy  output  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-high, effective immediately, including mid-operation):
  - state=IDLE; pattern=4'b1011.
  - History, history count, shift register, bit counter, match_count and total_matches all 0.
  - z=0, out_valid=0, bit_valid=0, bit_out=0, busy=0, in_ready=1.
  - Any in-flight word is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the shift register, bit_cnt=WORD_W-1, match_count=0, go to SHIFT.
- cfg_we:
  - Honoured only in IDLE; ignored in SHIFT and DONE.
  - Loads the pattern and clears the 3-bit history and the history count.
  - If cfg_we and in_valid occur in the same cycle, both take effect: the word is scanned with the new pattern and cleared history.
- SHIFT:
  - bit_valid=1; bit_out = shift register MSB.
  - At each edge: history <= {history[1:0], bit_out}, history count saturates at 3, shift register shifts left, bit_cnt decrements.
  - When bit_cnt==0 at the edge, go to DONE.
  - Exactly WORD_W SHIFT cycles per word.
- Match rule:
  - A match occurs at an edge where a bit is consumed, history count==3 (three prior bits present), and {history, bit_out}==pattern.
  - Overlapping matches count.
  - History persists across words, so a pattern spanning two words counts in the word holding the completing bit.
- Match outputs:
  - z is registered: high for exactly one cycle after each matching edge; 0 otherwise, including in IDLE and DONE except for a match on the final bit.
  - On the same edge as z is set: match_count increments, and total_matches increments unless it is at all-ones (saturates, no wrap).
- Latency: for a word accepted at edge t0, bits are consumed at edges t0+1..t0+WORD_W and out_valid rises after edge t0+WORD_W. match_count is already final at that point.
- DONE:
  - out_valid=1; match_count held stable; in_ready=0.
  - On out_ready, go to IDLE at the next edge; out_valid falls.
  - out_valid and match_count must not change while out_ready=0.
- Back-to-back words: minimum one IDLE cycle between DONE and the next accept; no bypass path.
- in_ready is a function of state only, never of in_valid.

Test Plan:
1. Reset, default pattern, send in_data=8'b1011_0110 with out_ready=1 -> bit_out sequence 1,0,1,1,0,1,1,0; z pulses after the 4th and 7th consumed bits; out_valid 8 cycles after accept edge with match_count=2; total_matches=2.
2. Continuing from idle history: send 8'b0000_0101 then 8'b1000_0000 -> first word match_count=0; second word match_count=1 (completing bit is its MSB), z one cycle after its first bit; total_matches=1 above prior.
3. Write cfg_pattern=4'b1111 with cfg_we and in_valid in the same IDLE cycle, in_data=8'hFF -> history cleared, matches on bits 4..8, match_count=5, z high 5 consecutive cycles.
4. Hold out_ready=0 for 5 cycles in DONE, pulse cfg_we and in_valid meanwhile -> out_valid and match_count stable, in_ready=0, no word accepted, pattern unchanged; out_ready=1 -> IDLE next edge.
5. Assert reset after 3 bits of a word -> immediately busy=0, z=0, out_valid=0, in_ready=1, counts 0; next word scanned with pattern 1011 and empty history (no match until 4 bits seen).
6. Force total_matches near all-ones (WORD_W=8, TOT_W=4, stream 8'hFF words with pattern 1111) -> total_matches saturates at 4'hF, no wrap.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller with a programmable 4-bit overlapping
// Moore pattern detector and per-word / saturating total match counters.
module seq_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4,
    parameter int TOT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_pattern,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  match_count,
    output logic [TOT_W-1:0]  total_matches,
    output logic              busy
);

    localparam int BC_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_pattern;
    logic [2:0]        r_hist;
    logic [1:0]        r_hcnt;
    logic [WORD_W-1:0] r_shift;
    logic [BC_W-1:0]   r_bitcnt;
    logic              r_z;
    logic [CNT_W-1:0]  r_mcnt;
    logic [TOT_W-1:0]  r_total;
    logic              w_bit;
    logic              w_accept;
    logic              w_cfg;
    logic              w_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        out_valid = 1'b0;
        w_bit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                bit_valid = 1'b1;
                w_bit     = r_shift[WORD_W-1];
                if (r_bitcnt == '0) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = in_valid & in_ready;
    assign w_cfg    = cfg_we & (r_state == S_IDLE);
    // A match needs three prior bits of history plus the bit being consumed
    assign w_match  = bit_valid && (r_hcnt == 2'd3) &&
                      ({r_hist, w_bit} == r_pattern);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern <= 4'b1011;
            r_hist    <= '0;
            r_hcnt    <= '0;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_z       <= 1'b0;
            r_mcnt    <= '0;
            r_total   <= '0;
        end else begin
            r_z <= w_match;
            if (w_cfg) begin
                r_pattern <= cfg_pattern;
                r_hist    <= '0;
                r_hcnt    <= '0;
            end
            if (w_accept) begin
                r_shift  <= in_data;
                r_bitcnt <= BC_W'(WORD_W - 1);
                r_mcnt   <= '0;
            end
            if (bit_valid) begin
                r_hist   <= {r_hist[1:0], w_bit};
                r_shift  <= r_shift << 1;
                r_bitcnt <= r_bitcnt - 1'b1;
                if (r_hcnt != 2'd3) r_hcnt <= r_hcnt + 1'b1;
            end
            if (w_match) begin
                r_mcnt <= r_mcnt + 1'b1;
                if (r_total != '1) r_total <= r_total + 1'b1;
            end
        end
    end

    assign bit_out       = w_bit;
    assign z             = r_z;
    assign match_count   = r_mcnt;
    assign total_matches = r_total;
    assign busy          = (r_state != S_IDLE);

endmodule
